// File: rtl/btb_update_sched.sv
// btb_update_sched
// Collects BTB update requests from two branch units into a 4-entry FIFO and
// drains them into the BTB write port whenever the front end is not reading.
// A head entry that waits STARVE_LIM consecutive cycles behind fetch reads is
// written anyway, with BtbStop raised so the BTB pipeline register holds.
// Optional feature: define BTB_UPD_BYPASS_EN to let a granted request go
// straight to the write port when the queue is empty and fetch is idle.
module btb_update_sched #(
   parameter int STARVE_LIM = 7
) (
   input  logic        Clk,
   input  logic        Rest,
   input  logic        ReqAValid,
   input  logic [31:0] ReqAPc,
   input  logic [31:0] ReqATarget,
   input  logic [2:0]  ReqAType,
   output logic        ReqAReady,
   input  logic        ReqBValid,
   input  logic [31:0] ReqBPc,
   input  logic [31:0] ReqBTarget,
   input  logic [2:0]  ReqBType,
   output logic        ReqBReady,
   input  logic        FetchReq,
   output logic        WrEn,
   output logic [31:0] WrPc,
   output logic [31:0] WrTarget,
   output logic [2:0]  WrType,
   output logic        BtbStop,
   output logic [2:0]  QCount
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic [2:0]  br_type;
   } upd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      FORCE = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);

   upd_t        mem_reg [4];
   logic [1:0]  wr_ptr_reg, wr_ptr_next;
   logic [1:0]  rd_ptr_reg, rd_ptr_next;
   logic [2:0]  count_reg, count_next;
   state_t      state_reg, state_next;
   logic [3:0]  starve_reg, starve_next, starve_inc;
   logic        prio_reg, prio_next;       // 0: A has priority, 1: B

   logic        wr_en_reg;
   logic        btb_stop_reg;
   logic [31:0] wr_pc_reg;
   logic [31:0] wr_target_reg;
   logic [2:0]  wr_type_reg;

   logic        full;
   logic        grant_a, grant_b;
   logic        accept;
   logic        enq;
   logic        pop;
   logic        force_wr;
   logic        bypass;
   logic        has_more;
   upd_t        req_entry;
   upd_t        head_entry;

   assign head_entry = mem_reg[rd_ptr_reg];
   assign starve_inc = (starve_reg == 4'hF) ? 4'hF : starve_reg + 4'd1;

   // Round-robin arbitration between the two requesters; nothing is accepted while full
   always_comb begin
      full      = (count_reg == 3'd4);
      grant_a   = ReqAValid & (~ReqBValid | ~prio_reg);
      grant_b   = ReqBValid & (~ReqAValid | prio_reg);
      ReqAReady = grant_a & ~full;
      ReqBReady = grant_b & ~full;
      accept    = ReqAReady | ReqBReady;
      prio_next = prio_reg;
      if (ReqAValid & ReqBValid & accept) begin
         prio_next = ~prio_reg;
      end
      req_entry.pc      = ReqAReady ? ReqAPc     : ReqBPc;
      req_entry.target  = ReqAReady ? ReqATarget : ReqBTarget;
      req_entry.br_type = ReqAReady ? ReqAType   : ReqBType;
   end

   // Scheduler: decides enqueue/pop, starvation counting and next state
   always_comb begin
      state_next  = state_reg;
      starve_next = starve_reg;
      pop         = 1'b0;
      force_wr    = 1'b0;
      enq         = accept;
      bypass      = 1'b0;
`ifdef BTB_UPD_BYPASS_EN
      // Empty queue and idle fetch port: write the request straight through
      if ((state_reg == IDLE) && !FetchReq && accept) begin
         bypass = 1'b1;
         enq    = 1'b0;
      end
`endif
      // Entries left after popping the head, counting this cycle's enqueue
      has_more = (count_reg > 3'd1) | enq;
      case (state_reg)
         IDLE: begin
            starve_next = 4'd0;
            if (enq) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (!FetchReq) begin
               pop         = 1'b1;
               starve_next = 4'd0;
               state_next  = has_more ? WAIT : IDLE;
            end else begin
               starve_next = starve_inc;
               if (starve_inc >= STARVE_LIM_W) begin
                  state_next = FORCE;
               end
            end
         end
         FORCE: begin
            pop         = 1'b1;
            force_wr    = 1'b1;
            starve_next = 4'd0;
            state_next  = has_more ? WAIT : IDLE;
         end
         default: begin
            state_next  = IDLE;
            starve_next = 4'd0;
         end
      endcase
   end

   // Pointer and occupancy bookkeeping
   always_comb begin
      wr_ptr_next = wr_ptr_reg + {1'b0, enq};
      rd_ptr_next = rd_ptr_reg + {1'b0, pop};
      count_next  = count_reg;
      if (enq & ~pop) begin
         count_next = count_reg + 3'd1;
      end else if (pop & ~enq) begin
         count_next = count_reg - 3'd1;
      end
   end

   // Control state registers
   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         wr_ptr_reg <= 2'd0;
         rd_ptr_reg <= 2'd0;
         count_reg  <= 3'd0;
         state_reg  <= IDLE;
         starve_reg <= 4'd0;
         prio_reg   <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
         state_reg  <= state_next;
         starve_reg <= starve_next;
         prio_reg   <= prio_next;
      end
   end

   // Queue storage; contents need no reset because occupancy gates every read
   always_ff @(posedge Clk) begin
      if (enq) begin
         mem_reg[wr_ptr_reg] <= req_entry;
      end
   end

   // Registered BTB write port; fields hold their last value between writes
   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         wr_en_reg     <= 1'b0;
         btb_stop_reg  <= 1'b0;
         wr_pc_reg     <= 32'd0;
         wr_target_reg <= 32'd0;
         wr_type_reg   <= 3'd0;
      end else begin
         wr_en_reg    <= pop | bypass;
         btb_stop_reg <= force_wr;
         if (pop) begin
            wr_pc_reg     <= head_entry.pc;
            wr_target_reg <= head_entry.target;
            wr_type_reg   <= head_entry.br_type;
         end else if (bypass) begin
            wr_pc_reg     <= req_entry.pc;
            wr_target_reg <= req_entry.target;
            wr_type_reg   <= req_entry.br_type;
         end
      end
   end

   assign WrEn     = wr_en_reg;
   assign BtbStop  = btb_stop_reg;
   assign WrPc     = wr_pc_reg;
   assign WrTarget = wr_target_reg;
   assign WrType   = wr_type_reg;
   assign QCount   = count_reg;

endmodule

// File: tb/tb_btb_update_sched.sv
// Testbench for btb_update_sched: directed scenarios with literal expectations
// plus a queue-based reference model checked on every falling clock edge.
module tb_btb_update_sched;

   localparam int STARVE_LIM = 7;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tgt;
      logic [2:0]  typ;
   } ent_t;

   logic        Clk;
   logic        Rest;
   logic        ReqAValid, ReqBValid;
   logic [31:0] ReqAPc, ReqATarget, ReqBPc, ReqBTarget;
   logic [2:0]  ReqAType, ReqBType;
   logic        ReqAReady, ReqBReady;
   logic        FetchReq;
   logic        WrEn;
   logic [31:0] WrPc, WrTarget;
   logic [2:0]  WrType;
   logic        BtbStop;
   logic [2:0]  QCount;

   int checks   = 0;
   int failures = 0;
   int lat;

   btb_update_sched #(.STARVE_LIM(STARVE_LIM)) dut (
      .Clk(Clk), .Rest(Rest),
      .ReqAValid(ReqAValid), .ReqAPc(ReqAPc), .ReqATarget(ReqATarget),
      .ReqAType(ReqAType), .ReqAReady(ReqAReady),
      .ReqBValid(ReqBValid), .ReqBPc(ReqBPc), .ReqBTarget(ReqBTarget),
      .ReqBType(ReqBType), .ReqBReady(ReqBReady),
      .FetchReq(FetchReq),
      .WrEn(WrEn), .WrPc(WrPc), .WrTarget(WrTarget), .WrType(WrType),
      .BtbStop(BtbStop), .QCount(QCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   ent_t        mq[$];
   logic        m_prio;
   int          m_wait;
   bit          m_force_due;
   logic        m_wren, m_stop;
   logic [31:0] m_pc, m_tgt;
   logic [2:0]  m_type;

   task automatic model_reset();
      mq.delete();
      m_prio      = 1'b0;
      m_wait      = 0;
      m_force_due = 1'b0;
      m_wren      = 1'b0;
      m_stop      = 1'b0;
      m_pc        = 32'd0;
      m_tgt       = 32'd0;
      m_type      = 3'd0;
   endtask

   // Compare DUT to model each falling edge, then advance the model by one cycle
   initial begin
      bit   full, ga, gb, ra, rb, acc, byp;
      ent_t h, ne;
      model_reset();
      forever begin
         @(negedge Clk);
         if (Rest) begin
            model_reset();
            chk("rst_qcount", QCount, 0);
            chk("rst_wren", WrEn, 0);
            chk("rst_stop", BtbStop, 0);
         end else begin
            chk("m_wren", WrEn, m_wren);
            chk("m_stop", BtbStop, m_stop);
            chk("m_pc", WrPc, m_pc);
            chk("m_tgt", WrTarget, m_tgt);
            chk("m_type", WrType, m_type);
            chk("m_qcount", QCount, mq.size());
            full = (mq.size() == 4);
            ga   = ReqAValid && (!ReqBValid || !m_prio);
            gb   = ReqBValid && (!ReqAValid || m_prio);
            ra   = ga && !full;
            rb   = gb && !full;
            chk("m_ready_a", ReqAReady, ra);
            chk("m_ready_b", ReqBReady, rb);
            acc  = ra || rb;
            if (ReqAValid && ReqBValid && acc) m_prio = !m_prio;
            ne.pc  = ra ? ReqAPc : ReqBPc;
            ne.tgt = ra ? ReqATarget : ReqBTarget;
            ne.typ = ra ? ReqAType : ReqBType;
            byp = 1'b0;
`ifdef BTB_UPD_BYPASS_EN
            if (mq.size() == 0 && !FetchReq && acc) byp = 1'b1;
`endif
            m_wren = 1'b0;
            m_stop = 1'b0;
            if (m_force_due) begin
               h = mq.pop_front();
               m_wren = 1'b1; m_stop = 1'b1;
               m_pc = h.pc; m_tgt = h.tgt; m_type = h.typ;
               m_force_due = 1'b0;
               m_wait = 0;
            end else if (mq.size() > 0) begin
               if (!FetchReq) begin
                  h = mq.pop_front();
                  m_wren = 1'b1;
                  m_pc = h.pc; m_tgt = h.tgt; m_type = h.typ;
                  m_wait = 0;
               end else begin
                  m_wait++;
                  if (m_wait >= STARVE_LIM) m_force_due = 1'b1;
               end
            end else if (byp) begin
               m_wren = 1'b1;
               m_pc = ne.pc; m_tgt = ne.tgt; m_type = ne.typ;
            end
            if (acc && !byp) mq.push_back(ne);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      Rest = 1'b1;
      ReqAValid = 1'b0; ReqBValid = 1'b0; FetchReq = 1'b0;
      ReqAPc = 32'd0; ReqATarget = 32'd0; ReqAType = 3'd0;
      ReqBPc = 32'd0; ReqBTarget = 32'd0; ReqBType = 3'd0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_wren", WrEn, 0);
      chk("reset_stop", BtbStop, 0);
      chk("reset_wrpc", WrPc, 0);
      chk("reset_wrtgt", WrTarget, 0);
      chk("reset_wrtype", WrType, 0);
      chk("reset_qcount", QCount, 0);
      Rest = 1'b0;
      tick();
      $display("txn reset released");

      // Single A request, fetch idle
`ifdef BTB_UPD_BYPASS_EN
      lat = 1;
`else
      lat = 2;
`endif
      ReqAValid = 1'b1; ReqAPc = 32'h1C000010; ReqATarget = 32'h1C000100; ReqAType = 3'd3;
      FetchReq = 1'b0;
      #1 chk("t28_ready_a", ReqAReady, 1);
      tick();
      ReqAValid = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         if (k < lat) begin
            chk("t28_early_wren", WrEn, 0);
            tick();
         end
      end
      chk("t28_wren", WrEn, 1);
      chk("t28_wrpc", WrPc, 32'h1C000010);
      chk("t28_wrtgt", WrTarget, 32'h1C000100);
      chk("t28_wrtype", WrType, 3'd3);
      chk("t28_stop", BtbStop, 0);
      tick();
      chk("t28_single_write", WrEn, 0);
      $display("txn single A write pc=%h latency=%0d", 32'h1C000010, lat);
      tick();

      // One entry starved behind fetch reads
      ReqAValid = 1'b1; ReqAPc = 32'h20000040; ReqATarget = 32'h20000400; ReqAType = 3'd5;
      FetchReq = 1'b1;
      tick();
      ReqAValid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k < 9) begin
            chk("t30_wait_wren", WrEn, 0);
            tick();
         end
      end
      chk("t30_force_wren", WrEn, 1);
      chk("t30_force_stop", BtbStop, 1);
      chk("t30_force_pc", WrPc, 32'h20000040);
      tick();
      chk("t30_stop_one_cycle", BtbStop, 0);
      chk("t30_qcount", QCount, 0);
      $display("txn forced write pc=%h", 32'h20000040);
      FetchReq = 1'b0;
      tick();

      // Both units requesting while fetch holds the port, then drain while full
      ReqAValid = 1'b1; ReqAPc = 32'h10000A00; ReqATarget = 32'h10000AA0; ReqAType = 3'd1;
      ReqBValid = 1'b1; ReqBPc = 32'h10000B00; ReqBTarget = 32'h10000BB0; ReqBType = 3'd2;
      FetchReq = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t29_grant_a", ReqAReady, (k % 2) == 0);
         chk("t29_grant_b", ReqBReady, (k % 2) == 1);
         $display("txn grant cycle=%0d a=%0b b=%0b", k, ReqAReady, ReqBReady);
         tick();
      end
      #1;
      chk("t29_qcount_full", QCount, 4);
      chk("t29_full_ready_a", ReqAReady, 0);
      chk("t29_full_ready_b", ReqBReady, 0);
      FetchReq = 1'b0;
      #1;
      chk("t31_popfull_ready_a", ReqAReady, 0);
      chk("t31_popfull_ready_b", ReqBReady, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("t31_wren", WrEn, 1);
         chk("t31_order_pc", WrPc, ((k % 2) == 0) ? 32'h10000A00 : 32'h10000B00);
         $display("txn drain write %0d pc=%h", k, WrPc);
      end
      ReqAValid = 1'b0; ReqBValid = 1'b0;
      repeat (5) tick();
      chk("t31_drained", QCount, 0);

      // Mixed traffic pattern exercising full queue, forced writes and bypass
      for (int i = 0; i < 160; i++) begin
         ReqAValid  = (i % 3) != 0;
         ReqBValid  = (i % 5) < 2;
         FetchReq   = (i % 13) < 10;
         ReqAPc     = 32'h40000000 + 32'(i * 16);
         ReqATarget = ReqAPc ^ 32'h0000FFFF;
         ReqAType   = 3'(i);
         ReqBPc     = 32'h50000000 + 32'(i * 16);
         ReqBTarget = ReqBPc ^ 32'h00FF00FF;
         ReqBType   = 3'(i + 4);
         tick();
         if (WrEn) $display("txn mixed write pc=%h stop=%0b q=%0d", WrPc, BtbStop, QCount);
      end
      ReqAValid = 1'b0; ReqBValid = 1'b0; FetchReq = 1'b0;
      repeat (6) tick();
      chk("mix_drained", QCount, 0);

      // Reset with three entries queued and a write in flight
      ReqAValid = 1'b1; ReqATarget = 32'h30000300; ReqAType = 3'd6; FetchReq = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ReqAPc = 32'h30000000 + 32'(k * 4);
         tick();
      end
      ReqAPc = 32'h3000000C;
      FetchReq = 1'b0;
      tick();
      chk("t32_pre_qcount", QCount, 3);
      chk("t32_pre_wren", WrEn, 1);
      chk("t32_pre_pc", WrPc, 32'h30000000);
      ReqAValid = 1'b0;
      Rest = 1'b1;
      #1;
      chk("t32_async_qcount", QCount, 0);
      chk("t32_async_wren", WrEn, 0);
      $display("txn reset mid-operation");
      tick();
      tick();
      Rest = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t32_no_write", WrEn, 0);
         chk("t32_empty", QCount, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btb_update_sched.md
BTB_UPDATE_SCHED -- requirements
Module: btb_update_sched

Interface
REQ-001 Parameter STARVE_LIM, default 7: max consecutive cycles a queued update waits behind fetch reads.
REQ-002 Clk  in  1  single clock, all state on rising edge.
REQ-003 Rest  in  1  reset, asynchronous, active-high.
REQ-004 ReqAValid / ReqBValid  in  1  update request from branch unit A / B.
REQ-005 ReqAPc / ReqBPc  in  32  branch PC; ReqATarget / ReqBTarget  in  32  target; ReqAType / ReqBType  in  3  branch type.
REQ-006 ReqAReady / ReqBReady  out  1  request accepted this cycle; combinational.
REQ-007 FetchReq  in  1  front-end BTB read lookup in progress this cycle.
REQ-008 WrEn  out  1  BTB write strobe; WrPc  out  32; WrTarget  out  32; WrType  out  3; all registered.
REQ-009 BtbStop  out  1  registered stop to the BTB pipeline register stage; high only in forced-write cycles.
REQ-010 QCount  out  3  current queue occupancy, 0..4.

Function
REQ-011 Queue: 4-entry FIFO of {pc, target, type}, circular 2-bit read/write pointers, wrap 3->0.
REQ-012 At most one enqueue per cycle; arbitration round-robin via 1-bit priority flag, flag toggles only when both valid and one granted.
REQ-013 Single valid requester is granted if queue not full; ReqXReady = grant & !full; handshake completes when Valid & Ready.
REQ-014 Full (QCount==4): both Ready low, even if a pop occurs the same cycle.
REQ-015 FSM states IDLE (queue empty), WAIT (queue non-empty, fetch holding port), FORCE (forced write).
REQ-016 IDLE->WAIT on enqueue; no write issued from IDLE.
REQ-017 WAIT with FetchReq=0: pop head; WrEn=1 with head fields next cycle; starvation counter cleared; stay WAIT if entries remain, else IDLE.
REQ-018 WAIT with FetchReq=1: no pop, starvation counter +1; when counter==STARVE_LIM go FORCE.
REQ-019 FORCE: pop head unconditionally; next cycle WrEn=1 and BtbStop=1 together for exactly one cycle; counter cleared; return WAIT or IDLE per remaining entries.
REQ-020 Starvation counter 4 bits, saturating, counts only while head waits.
REQ-021 Simultaneous enqueue and pop: QCount unchanged, both pointers advance.
REQ-022 WrEn low in any cycle with no pop in the prior cycle; Wr* fields hold last value when WrEn low.
REQ-023 Queue order is strict FIFO; no entry dropped or duplicated.

Reset
REQ-024 Rest high asynchronously forces: pointers 0, QCount 0, FSM IDLE, counter 0, priority flag to A, WrEn 0, BtbStop 0, WrPc/WrTarget 0, WrType 0.
REQ-025 Reset mid-operation discards all queued updates; no write issued in the first cycle after deassertion.

Configuration
REQ-026 Macro BTB_UPD_BYPASS_EN defined: when queue empty, FetchReq=0 and a request is granted, the request is written directly (WrEn next cycle) without enqueue; QCount stays 0.
REQ-027 Macro undefined: every granted request is enqueued; minimum request-to-WrEn latency 2 cycles.

Verification
REQ-028 Single A request PC=0x1C000010, target 0x1C000100, type 3, FetchReq=0 -> WrEn high 2 cycles later (1 with BTB_UPD_BYPASS_EN) with those values, BtbStop 0.
REQ-029 A and B valid together 4 cycles, FetchReq=1 -> grants alternate A,B,A,B; QCount reaches 4; both Ready low in fifth cycle.
REQ-030 One entry queued, FetchReq held 1 -> after 7 waiting cycles, WrEn=1 and BtbStop=1 for one cycle; counter cleared.
REQ-031 Queue full, FetchReq=0, requests held valid -> one pop per cycle, Ready low in pop cycle while full, writes in enqueue order.
REQ-032 Rest asserted with 3 entries queued -> QCount 0, WrEn 0 immediately; no write after deassertion without new requests.
